// File: rtl/controlador_barrido_teclado_if.sv
// Key-code handoff between the keypad scan controller and its consumer.
//   key_code_o  : FIFO head {row_index[1:0], column[1:0]}
//   key_valid_o : FIFO not empty
//   key_ready_i : consumer accepts the head when key_valid_o=1
// master = scan controller, slave = consumer.
interface controlador_barrido_teclado_if;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       key_ready_i;

    modport master (output key_code_o, output key_valid_o, input key_ready_i);
    modport slave  (input key_code_o, input key_valid_o, output key_ready_i);
endinterface

// File: rtl/controlador_barrido_teclado.sv
// Hex keypad scan sequencer: drives the column index, synchronizes and
// debounces the row lines, captures one code per press (repeat lockout until
// release) and buffers codes in a first-word-fall-through FIFO.
// Ports:
//   clk_i, reset_i  : clock, asynchronous active-high reset
//   filas_i         : raw row lines, active-high, asynchronous
//   columna_o       : column being scanned
//   overflow_o      : one-cycle pulse when a captured code is dropped (FIFO full)
//   fifo_count_o    : entries held
//   kbd_if          : key code valid/ready handoff (master side)
// Optional feature: define TYPEMATIC_EN to repeat the held key's code every
// REPEAT_CYCLES clocks while the pattern stays unchanged.
module controlador_barrido_teclado #(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4
`ifdef TYPEMATIC_EN
    ,
    parameter int unsigned REPEAT_CYCLES   = 64
`endif
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [3:0]                  filas_i,
    output logic [1:0]                  columna_o,
    output logic                        overflow_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    controlador_barrido_teclado_if.master kbd_if
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PUSH, WAIT_RELEASE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DEB_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         pat_q, pat_d;
    logic [3:0]         sync_q, rows_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         head_q, head_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic [3:0]         mem_q [FIFO_DEPTH];
    logic               pop, push_we, fifo_full;
    logic [3:0]         key_code;
`ifdef TYPEMATIC_EN
    localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    logic [REP_W-1:0]   rep_q, rep_d;
`endif

    // Lowest set row wins when several keys share the column.
    function automatic logic [1:0] low_row(input logic [3:0] v);
        casez (v)
            4'b???1: return 2'd0;
            4'b??10: return 2'd1;
            4'b?100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    assign pop       = valid_q & kbd_if.key_ready_i;
    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign key_code  = {low_row(pat_q), col_q};
    // A pop on the same edge frees a slot for the incoming code.
    assign push_we   = (state_q == PUSH) && (!fifo_full || pop);

    // Next-state and FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
`ifdef TYPEMATIC_EN
        rep_d    = rep_q;
`endif
        wr_ptr_d = push_we ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_we) - CNT_W'(pop);
        valid_d  = (count_d != '0);
        ovf_d    = (state_q == PUSH) && !push_we;
        head_d   = head_q;

        // Head register: holds the last value once the FIFO runs empty.
        if (push_we && ((count_q == '0) || (pop && count_q == CNT_W'(1))))
            head_d = key_code;
        else if (pop && count_q > CNT_W'(1))
            head_d = mem_q[rd_ptr_q + PTR_W'(1)];

        unique case (state_q)
            SCAN: begin
                if (rows_q != '0) begin
                    state_d = DEBOUNCE;
                    pat_d   = rows_q;
                    cnt_d   = DEB_W'(1);
                end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                    div_d = '0;
                    col_d = col_q + 2'd1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DEBOUNCE: begin
                if (rows_q == pat_q) begin
                    if (cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) state_d = PUSH;
                    else                                       cnt_d = cnt_q + DEB_W'(1);
                end else begin
                    state_d = SCAN;
                    div_d   = '0;
                end
            end
            PUSH: begin
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
`ifdef TYPEMATIC_EN
                rep_d   = '0;
`endif
            end
            WAIT_RELEASE: begin
                if (rows_q == '0) begin
`ifdef TYPEMATIC_EN
                    rep_d = '0;
`endif
                    if (cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                        state_d = SCAN;
                        div_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DEB_W'(1);
                    end
                end else begin
                    cnt_d = '0;
`ifdef TYPEMATIC_EN
                    // Held pattern repeats; any change restarts the period.
                    if (rows_q == pat_q) begin
                        if (rep_q == REP_W'(REPEAT_CYCLES - 1)) state_d = PUSH;
                        else                                    rep_d = rep_q + REP_W'(1);
                    end else begin
                        rep_d = '0;
                    end
`endif
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // State, synchronizer and FIFO control registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= SCAN;
            col_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            pat_q    <= '0;
            sync_q   <= '0;
            rows_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef TYPEMATIC_EN
            rep_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            sync_q   <= filas_i;
            rows_q   <= sync_q;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
`ifdef TYPEMATIC_EN
            rep_q    <= rep_d;
`endif
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else if (push_we) begin
            mem_q[wr_ptr_q] <= key_code;
        end
    end

    assign columna_o          = col_q;
    assign overflow_o         = ovf_q;
    assign fifo_count_o       = count_q;
    assign kbd_if.key_code_o  = head_q;
    assign kbd_if.key_valid_o = valid_q;

endmodule

// File: tb/tb_controlador_barrido_teclado.sv
module tb_controlador_barrido_teclado;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DEB   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] filas;
    logic [1:0] col;
    logic       ovf;
    logic [2:0] fcount;
    logic [3:0] key_matrix [4];
    logic       ready_ctl;
    logic       rnd_ready = 1'b0;
    bit         rand_ready_en = 1'b0;

    int         tests_run = 0;
    int         failures  = 0;
    int         ovf_seen  = 0;
    int         exp_ovf   = 0;
    int         rx_count  = 0;
    logic [3:0] exp_q [$];

    controlador_barrido_teclado_if kif();

    controlador_barrido_teclado #(
        .SCAN_DIV(4), .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .reset_i(rst), .filas_i(filas), .columna_o(col),
        .overflow_o(ovf), .fifo_count_o(fcount), .kbd_if(kif)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key closes its row only while its column is driven.
    always_comb filas = key_matrix[col];
    always_comb kif.key_ready_i = rand_ready_en ? rnd_ready : ready_ctl;

    always @(posedge clk) begin
        #1 rnd_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected code: lowest pressed row in the column, then the column.
    function automatic logic [3:0] ref_code(input logic [1:0] c, input logic [3:0] mask);
        for (int r = 0; r < 4; r++)
            if (mask[r]) return {2'(r), c};
        return 4'h0;
    endfunction

    // Scoreboard monitor: compares every accepted code with the queue head.
    always @(negedge clk) begin : monitor
        logic [3:0] e;
        if (!rst) begin
            if (kif.key_valid_o === 1'b1 && kif.key_ready_i === 1'b1) begin
                tests_run++;
                rx_count++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_code: got %0h expected none", kif.key_code_o);
                end else begin
                    e = exp_q.pop_front();
                    if (kif.key_code_o !== e) begin
                        failures++;
                        $display("FAIL key_code: got %0h expected %0h", kif.key_code_o, e);
                    end
                end
            end
            if (ovf === 1'b1) ovf_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_col_not(input logic [1:0] c);
        for (int i = 0; i < 40 && col == c; i++) tick(1);
        check("col_leave", 32'(col != c), 32'd1);
    endtask

    // Returns right after the edge on which the column becomes c.
    task automatic wait_col_eq(input logic [1:0] c);
        for (int i = 0; i < 80 && col != c; i++) tick(1);
        check("col_reach", 32'(col), 32'(c));
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // One press. pulse_ready raises key_ready_i only during the PUSH cycle
    // (edges: column match E0, DEBOUNCE entry E3, PUSH between E6 and E7).
    task automatic press(input logic [1:0] c, input logic [3:0] mask,
                         input int hold, input bit pulse_ready);
        wait_col_not(c);
        if (!rand_ready_en && ready_ctl == 1'b0 && !pulse_ready && exp_q.size() >= DEPTH)
            exp_ovf++;
        else
            exp_q.push_back(ref_code(c, mask));
        key_matrix[c] = mask;
        if (pulse_ready) begin
            wait_col_eq(c);
            tick(6);
            ready_ctl = 1'b1;
            tick(1);
            ready_ctl = 1'b0;
            tick(hold - 7);
        end else begin
            tick(hold);
        end
        key_matrix[c] = 4'h0;
        tick(24);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rx0, bad, reps;
        logic [1:0] rc;
        logic [3:0] rm;
        for (int i = 0; i < 4; i++) key_matrix[i] = 4'h0;
        ready_ctl = 1'b0;
        rst = 1'b1;
        tick(3);
        check("rst_col", 32'(col), 32'd0);
        check("rst_valid", 32'(kif.key_valid_o), 32'd0);
        check("rst_code", 32'(kif.key_code_o), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_count", 32'(fcount), 32'd0);
        rst = 1'b0;
        tick(1);

        // Reset while debouncing row1 on column 2 (cnt=2 after E4).
        key_matrix[2] = 4'b0010;
        wait_col_eq(2);
        tick(4);
        rst = 1'b1;
        #1;
        check("midrst_col", 32'(col), 32'd0);
        check("midrst_valid", 32'(kif.key_valid_o), 32'd0);
        check("midrst_count", 32'(fcount), 32'd0);
        key_matrix[2] = 4'h0;
        tick(2);
        rst = 1'b0;
        tick(40);
        check("midrst_nocode", 32'(fcount), 32'd0);
        check("midrst_rx", 32'(rx_count), 32'd0);

        // Row 2 on column 3: latency, frozen column, single code 4'b1011.
        ready_ctl = 1'b1;
        wait_col_not(3);
        exp_q.push_back(ref_code(2'd3, 4'b0100));
        rx0 = rx_count;
        key_matrix[3] = 4'b0100;
        wait_col_eq(3);
        n = 0;
        while (kif.key_valid_o !== 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        check("latency", 32'(n), 32'(DEB + 3));
        check("code_col3", 32'(kif.key_code_o), 32'hB);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            if (col != 2'd3) bad++;
        end
        check("col_frozen", 32'(bad), 32'd0);
        key_matrix[3] = 4'h0;
        tick(24);
        check("one_code", 32'(rx_count - rx0), 32'd1);
        check("pop_empty_count", 32'(fcount), 32'd0);
        check("pop_empty_valid", 32'(kif.key_valid_o), 32'd0);

        // Bouncy press and release: one code only.
        wait_col_not(3);
        exp_q.push_back(ref_code(2'd3, 4'b0100));
        rx0 = rx_count;
        for (int i = 0; i < 5; i++) begin
            key_matrix[3] = 4'b0100; tick(2);
            key_matrix[3] = 4'b0000; tick(2);
        end
        check("bounce_no_push", 32'(rx_count - rx0), 32'd0);
        key_matrix[3] = 4'b0100;
        tick(40);
        for (int i = 0; i < 5; i++) begin
            key_matrix[3] = 4'b0000; tick(2);
            key_matrix[3] = 4'b0100; tick(2);
        end
        key_matrix[3] = 4'b0000;
        tick(30);
        check("bounce_one_code", 32'(rx_count - rx0), 32'd1);

        // Consumer stalled: six presses into a 4-deep FIFO.
        ready_ctl = 1'b0;
        press(2'd0, 4'b0001, 40, 1'b0);
        press(2'd1, 4'b0010, 40, 1'b0);
        press(2'd2, 4'b0100, 40, 1'b0);
        press(2'd3, 4'b1000, 40, 1'b0);
        press(2'd0, 4'b0110, 40, 1'b0);
        press(2'd2, 4'b1001, 40, 1'b0);
        check("full_count", 32'(fcount), 32'(DEPTH));
        check("ovf_pulses", 32'(ovf_seen), 32'd2);
        check("full_head", 32'(kif.key_code_o), 32'h0);

        // Full FIFO with a pop on the PUSH cycle: accepted, no overflow.
        press(2'd1, 4'b1000, 40, 1'b1);
        check("pushpop_count", 32'(fcount), 32'(DEPTH));
        check("pushpop_ovf", 32'(ovf_seen), 32'd2);

        ready_ctl = 1'b1;
        wait_drain(60);
        tick(2);
        check("drained_count", 32'(fcount), 32'd0);
        check("drained_valid", 32'(kif.key_valid_o), 32'd0);
        check("hold_last_code", 32'(kif.key_code_o), 32'hD);

        // Long hold after capture.
`ifdef TYPEMATIC_EN
        reps = 4;
`else
        reps = 1;
`endif
        wait_col_not(2);
        for (int i = 0; i < reps; i++) exp_q.push_back(ref_code(2'd2, 4'b0010));
        rx0 = rx_count;
        key_matrix[2] = 4'b0010;
        n = 0;
        while (kif.key_valid_o !== 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        check("hold_capture", 32'(kif.key_valid_o), 32'd1);
        tick(200);
        key_matrix[2] = 4'h0;
        tick(30);
        check("hold_codes", 32'(rx_count - rx0), 32'(reps));

        // Randomized presses with a randomly stalling consumer.
        rand_ready_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_drain(100);
            rc = 2'($urandom_range(0, 3));
            rm = 4'($urandom_range(1, 15));
            press(rc, rm, int'($urandom_range(30, 45)), 1'b0);
        end
        wait_drain(100);
        rand_ready_en = 1'b0;
        tick(10);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        check("final_ovf", 32'(ovf_seen), 32'(exp_ovf));
        check("final_count", 32'(fcount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
